// File: rtl/router_pkg.sv
// Shared channel constants and helpers for the 4-way round-robin egress merge.
package router_pkg;

  localparam int CH_NUM   = 4;
  localparam int CH_IDX_W = 2;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Number of set bits in a per-channel mask (0..CH_NUM).
  function automatic logic [2:0] count_ones4(input logic [CH_NUM-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/router_rr_merge_if.sv
// Bus bundle between the 4-way router, the merge stage and its downstream consumer.
//
// Handshake: inputs din_vld[i] are fire-and-forget (the router cannot stall);
// din_rdy[i] is status only and reflects FIFO i not full. On the output side a
// word transfers on a rising edge where dout_vld & dout_rdy; while dout_vld is
// high and dout_rdy is low, dout/dout_src/dout_vld hold stable.
interface router_rr_merge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  import router_pkg::*;

  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] din1;
  logic [DATA_WIDTH-1:0] din2;
  logic [DATA_WIDTH-1:0] din3;
  logic [CH_NUM-1:0]     din_vld;
  logic [CH_NUM-1:0]     din_rdy;
  logic [DATA_WIDTH-1:0] dout;
  ch_idx_t               dout_src;
  logic                  dout_vld;
  logic                  dout_rdy;
  logic [CNT_WIDTH-1:0]  drop_cnt;
  ch_idx_t               last_grant;  // debug view of the round-robin pointer

  modport master (
    output din0, din1, din2, din3, din_vld, dout_rdy,
    input  din_rdy, dout, dout_src, dout_vld, drop_cnt, last_grant
  );

  modport slave (
    input  din0, din1, din2, din3, din_vld, dout_rdy,
    output din_rdy, dout, dout_src, dout_vld, drop_cnt, last_grant
  );

endinterface

// File: rtl/router_ch_fifo.sv
// Per-channel synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module router_ch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/router_rr_merge.sv
// Egress merge: four per-channel FIFOs drained round-robin into one registered
// valid/ready stream tagged with the source channel; overflow is dropped and counted.
module router_rr_merge
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst,
  router_rr_merge_if.slave bus
);

  logic [DATA_WIDTH-1:0] din_arr [CH_NUM];
  logic [DATA_WIDTH-1:0] rd_data [CH_NUM];
  logic [CH_NUM-1:0]     full;
  logic [CH_NUM-1:0]     empty;
  logic [CH_NUM-1:0]     push;
  logic [CH_NUM-1:0]     pop;
  logic [CH_NUM-1:0]     drop;

  ch_idx_t               grant;
  ch_idx_t               cand;
  logic                  grant_found;
  logic                  load;

  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  ch_idx_t               dout_src_q, dout_src_d;
  logic                  dout_vld_q, dout_vld_d;
  ch_idx_t               last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH:0]    drop_sum;
  logic [2:0]            n_drop;

  assign din_arr[0] = bus.din0;
  assign din_arr[1] = bus.din1;
  assign din_arr[2] = bus.din2;
  assign din_arr[3] = bus.din3;

  // Fullness is judged before the edge, so a same-edge pop never rescues a push.
  assign push = bus.din_vld & ~full;
  assign drop = bus.din_vld & full;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_fifo
    router_ch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[g]),
      .pop     (pop[g]),
      .wr_data (din_arr[g]),
      .rd_data (rd_data[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );
  end

  // Search starts one past the last grant; offset CH_NUM wraps back onto it.
  always_comb begin
    grant       = last_grant_q;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      cand = last_grant_q + ch_idx_t'(k);
      if (!grant_found && !empty[cand]) begin
        grant       = cand;
        grant_found = 1'b1;
      end
    end
  end

  assign load = (~dout_vld_q | bus.dout_rdy) & grant_found;

  always_comb begin
    pop          = '0;
    dout_d       = dout_q;
    dout_src_d   = dout_src_q;
    dout_vld_d   = dout_vld_q;
    last_grant_d = last_grant_q;
    if (load) begin
      pop[grant]   = 1'b1;
      dout_d       = rd_data[grant];
      dout_src_d   = grant;
      dout_vld_d   = 1'b1;
      last_grant_d = grant;
    end else if (dout_vld_q && bus.dout_rdy) begin
      dout_vld_d   = 1'b0;
    end
  end

  // One extra sum bit catches overflow so the counter pins at all-ones.
  always_comb begin
    n_drop     = count_ones4(drop);
    drop_sum   = {1'b0, drop_cnt_q} + {{(CNT_WIDTH-2){1'b0}}, n_drop};
    drop_cnt_d = drop_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : drop_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_src_q   <= '0;
      dout_vld_q   <= 1'b0;
      last_grant_q <= ch_idx_t'(CH_NUM - 1);
      drop_cnt_q   <= '0;
    end else begin
      dout_q       <= dout_d;
      dout_src_q   <= dout_src_d;
      dout_vld_q   <= dout_vld_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.din_rdy    = ~full;
  assign bus.dout       = dout_q;
  assign bus.dout_src   = dout_src_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.last_grant = last_grant_q;

endmodule

// File: tb/tb_router_rr_merge.sv
// Directed bench for router_rr_merge: a per-cycle vector table plus hand-written
// sequences for back-pressure, overflow/drop and mid-stream reset.
module tb_router_rr_merge;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] d0, d1, d2, d3;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_dout;
    logic [1:0]  e_src;
    logic [3:0]  e_din_rdy;
    logic [15:0] e_drop;
  } vec_t;

  localparam int NV = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t tbl [NV];
  logic [33:0] exp_q[$];
  logic [33:0] exp_w;

  router_rr_merge_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

  router_rr_merge #(
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] v,
                              input logic [31:0] a0, a1, a2, a3, input logic rd,
                              input logic ev, input logic [31:0] ed, input logic [1:0] es,
                              input logic [3:0] er, input logic [15:0] edc);
    vec_t t;
    t.rst = r; t.vld = v; t.d0 = a0; t.d1 = a1; t.d2 = a2; t.d3 = a3; t.rdy = rd;
    t.e_vld = ev; t.e_dout = ed; t.e_src = es; t.e_din_rdy = er; t.e_drop = edc;
    return t;
  endfunction

  // Driver: apply inputs, advance one edge, settle before sampling
  task automatic cyc(input logic r, input logic [3:0] v,
                     input logic [31:0] a0, a1, a2, a3, input logic rd);
    rst = r; bus.din_vld = v;
    bus.din0 = a0; bus.din1 = a1; bus.din2 = a2; bus.din3 = a3;
    bus.dout_rdy = rd;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string name, input logic ev, input logic [31:0] ed,
                         input logic [1:0] es);
    chk({name, ".vld"}, {63'd0, bus.dout_vld}, {63'd0, ev});
    chk({name, ".dout"}, {32'd0, bus.dout}, {32'd0, ed});
    chk({name, ".src"}, {62'd0, bus.dout_src}, {62'd0, es});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; bus.din_vld = '0; bus.dout_rdy = 1'b0;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;

    //              rst vld   d0     d1  d2            d3     rdy  vld dout          src rdy   drop
    tbl[0]  = mk(1, 4'h0, 0,     0,  0,            0,     0,   0, 32'h0,         0, 4'hF, 0);
    tbl[1]  = mk(1, 4'h0, 0,     0,  0,            0,     0,   0, 32'h0,         0, 4'hF, 0);
    tbl[2]  = mk(0, 4'h4, 0,     0,  32'hDEADBEEF, 0,     1,   0, 32'h0,         0, 4'hF, 0);
    tbl[3]  = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'hDEADBEEF,  2, 4'hF, 0);
    tbl[4]  = mk(0, 4'h0, 0,     0,  0,            0,     1,   0, 32'hDEADBEEF,  2, 4'hF, 0);
    tbl[5]  = mk(1, 4'h0, 0,     0,  0,            0,     1,   0, 32'h0,         0, 4'hF, 0);
    tbl[6]  = mk(0, 4'hF, 1,     2,  3,            4,     1,   0, 32'h0,         0, 4'hF, 0);
    tbl[7]  = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'd1,         0, 4'hF, 0);
    tbl[8]  = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'd2,         1, 4'hF, 0);
    tbl[9]  = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'd3,         2, 4'hF, 0);
    tbl[10] = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'd4,         3, 4'hF, 0);
    tbl[11] = mk(0, 4'h0, 0,     0,  0,            0,     1,   0, 32'd4,         3, 4'hF, 0);
    tbl[12] = mk(0, 4'h9, 32'h50, 0, 0,            32'h53, 1,  0, 32'd4,         3, 4'hF, 0);
    tbl[13] = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'h50,        0, 4'hF, 0);
    tbl[14] = mk(0, 4'h0, 0,     0,  0,            0,     1,   1, 32'h53,        3, 4'hF, 0);
    tbl[15] = mk(0, 4'h0, 0,     0,  0,            0,     1,   0, 32'h53,        3, 4'hF, 0);

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].rdy);
      chk_out($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_dout, tbl[i].e_src);
      chk($sformatf("vec%0d.din_rdy", i), {60'd0, bus.din_rdy}, {60'd0, tbl[i].e_din_rdy});
      chk($sformatf("vec%0d.drop", i), {48'd0, bus.drop_cnt}, {48'd0, tbl[i].e_drop});
    end

    // Back-pressure hold on ch1
    cyc(0, 4'h2, 0, 32'd10, 0, 0, 0);
    chk_out("bp.push10", 0, 32'h53, 3);
    cyc(0, 4'h2, 0, 32'd11, 0, 0, 0);
    chk_out("bp.push11", 1, 32'd10, 1);
    cyc(0, 4'h2, 0, 32'd12, 0, 0, 0);
    chk_out("bp.push12", 1, 32'd10, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'h0, 0, 0, 0, 0, 0);
      chk_out($sformatf("bp.hold%0d", i), 1, 32'd10, 1);
    end
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("bp.rel11", 1, 32'd11, 1);
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("bp.rel12", 1, 32'd12, 1);
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("bp.idle", 0, 32'd12, 1);

    // Overflow on ch0: register takes word 1, FIFO holds 2..5, 6 and 7 dropped
    for (int w = 1; w <= 7; w++) begin
      cyc(0, 4'h1, w, 0, 0, 0, 0);
    end
    chk_out("ovf.reg", 1, 32'd1, 0);
    chk("ovf.drop2", {48'd0, bus.drop_cnt}, 64'd2);
    chk("ovf.din_rdy", {60'd0, bus.din_rdy}, 64'hE);
    cyc(0, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
    chk("ovf.drop3", {48'd0, bus.drop_cnt}, 64'd3);
    chk("ovf.din_rdy2", {60'd0, bus.din_rdy}, 64'hE);
    chk_out("ovf.reg2", 1, 32'd1, 0);

    // Drain: round-robin from ch1, then ch0 alone back-to-back
    exp_q.push_back({2'd1, 32'hA1});
    exp_q.push_back({2'd2, 32'hA2});
    exp_q.push_back({2'd3, 32'hA3});
    for (int w = 2; w <= 5; w++) exp_q.push_back({2'd0, 32'(w)});
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      cyc(0, 4'h0, 0, 0, 0, 0, 1);
      chk_out("drain", 1, exp_w[31:0], exp_w[33:32]);
    end
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("drain.idle", 0, 32'd5, 0);
    chk("drain.din_rdy", {60'd0, bus.din_rdy}, 64'hF);

    // Reset mid-stream with all FIFOs partly full and the register loaded
    cyc(0, 4'hF, 32'h10, 32'h11, 32'h12, 32'h13, 0);
    cyc(0, 4'hF, 32'h20, 32'h21, 32'h22, 32'h23, 0);
    chk_out("mid.loaded", 1, 32'h11, 1);
    cyc(1, 4'h0, 0, 0, 0, 0, 0);
    chk_out("mid.rst", 0, 32'h0, 0);
    chk("mid.rst.drop", {48'd0, bus.drop_cnt}, 64'd0);
    chk("mid.rst.din_rdy", {60'd0, bus.din_rdy}, 64'hF);
    cyc(0, 4'h2, 0, 32'h77, 0, 0, 1);
    chk_out("mid.push", 0, 32'h0, 0);
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("mid.first", 1, 32'h77, 1);
    cyc(0, 4'h0, 0, 0, 0, 0, 1);
    chk_out("mid.empty", 0, 32'h77, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_rr_merge.md
Name: router_rr_merge

Overview:
- Egress-side merge stage that sits directly downstream of the 4-way address router.
- Accepts the four routed output channels (data plus a per-channel valid), buffers each channel in its own small FIFO, and merges them round-robin onto one valid/ready output stream.
- Tags each output word with the channel it came from.
- Because the router cannot stall, input overflow is dropped and counted; it is not back-pressured.

Parameters:
- DATA_WIDTH, 32, width of every data word.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, minimum 2.
- CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Synchronous, active-high reset.
- din0  in  DATA_WIDTH  Channel 0 data.
- din1  in  DATA_WIDTH  Channel 1 data.
- din2  in  DATA_WIDTH  Channel 2 data.
- din3  in  DATA_WIDTH  Channel 3 data.
- din_vld  in  4  Per-channel valid; bit i qualifies dini.
- din_rdy  out  4  Bit i = 1 when FIFO i is not full (status only).
- dout  out  DATA_WIDTH  Merged output data.
- dout_src  out  2  Channel index of the current dout word.
- dout_vld  out  1  Output word valid.
- dout_rdy  in  1  Downstream ready.
- drop_cnt  out  CNT_WIDTH  Total dropped input words, saturating.

Behaviour:
- Reset: clk, synchronous active-high rst.
  - All FIFOs empty; din_rdy = 4'b1111; dout = 0, dout_src = 0, dout_vld = 0; drop_cnt = 0; round-robin pointer last_grant = 3, so channel 0 has first priority.
  - Reset asserted mid-operation discards all buffered and output-register contents on that edge.
- Push: on an edge where din_vld[i] = 1:
  - If FIFO i is not full (evaluated before this edge), dini is written.
  - Otherwise the word is dropped and drop_cnt increments.
  - A full FIFO that is popped on the same edge still drops the push. din_rdy is therefore exactly !full, with no combinational path from dout_rdy.
- Multiple drops on one edge: drop_cnt adds the number of dropped channels (0..4) and saturates at all-ones.
- Output register: loads on an edge when (!dout_vld | dout_rdy) and at least one FIFO is non-empty.
  - The granted FIFO is popped; dout and dout_src are updated; dout_vld = 1.
  - If the register empties (dout_vld & dout_rdy) and no FIFO is non-empty, dout_vld -> 0. dout keeps its last value.
- Hold rule: while dout_vld = 1 and dout_rdy = 0, dout, dout_src and dout_vld are stable.
- Arbitration, round-robin over non-empty FIFOs:
  - Search order is last_grant+1, +2, +3, +4 (mod 4).
  - last_grant updates only on a load.
  - A single active channel may be granted back-to-back.
- Latency: a word pushed on edge k into an empty system with dout_vld = 0 is loaded on edge k+1 and is visible with dout_vld = 1 after edge k+1.
  - The FIFO and output register are not bypassed.
- Throughput: one word per cycle when dout_rdy is held high.
- Ordering: per-channel order is FIFO; no cross-channel ordering is guaranteed beyond round-robin.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits with a wrap bit.
  - full = (wr_ptr and rd_ptr addresses equal, wrap bits differ).
  - empty = pointers equal.
  - Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.

Decomposition:
- Package router_pkg: CH_NUM = 4, CH_IDX_W = 2, and a typedef for the channel index.
- One sub-module, router_ch_fifo (sync FIFO, DATA_WIDTH x FIFO_DEPTH, push/pop/full/empty), instantiated four times.
- Arbiter, output register and drop counter live in the top level.

Test Plan:
- Reset and idle: hold rst 2 cycles with din_vld = 0 -> dout_vld = 0, din_rdy = 4'hF, drop_cnt = 0, dout = 0 throughout.
- Single word: din2 = 32'hDEAD_BEEF, din_vld = 4'b0100 for 1 cycle, dout_rdy = 1 -> dout_vld high exactly one cycle, after the second edge, with dout = DEAD_BEEF and dout_src = 2.
- Round-robin:
  - Stimulus: one cycle of din_vld = 4'hF with din_i = i+1, dout_rdy = 1.
  - Required: outputs in order src 0, 1, 2, 3 with data 1, 2, 3, 4 on consecutive cycles.
  - Then push ch3 and ch0 together -> ch0 is served before ch3, because last_grant = 3.
- Back-pressure hold: fill ch1 with 10, 11, 12 and hold dout_rdy = 0 for 5 cycles -> dout = 10 and src = 1 stable.
  - Release -> 10, 11, 12 on consecutive cycles, no loss or duplication.
- Overflow and drop:
  - Stimulus: dout_rdy = 0; push 7 words into ch0 on consecutive cycles, with FIFO_DEPTH = 4.
  - Required: output register holds word 1, FIFO holds 2..5, words 6 and 7 are dropped, drop_cnt = 2, din_rdy[0] = 0.
  - Then pushing on all four channels on a cycle where only ch0 is full -> drop_cnt = 3.
- Reset mid-stream: assert rst while all FIFOs are partially full and dout_vld = 1 -> after the edge all outputs return to reset values, and the next push on ch1 is the first output.
